// File: rtl/score_digit_scanner.sv
// rtl/score_digit_scanner.sv - binary score to BCD via double-dabble, multiplexed onto a 7-segment bank
module score_digit_scanner #(
    parameter int NDIG        = 4,
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [31:0]      digit_val,
    output logic [NDIG-1:0]  anode_n
);

    localparam int BW = 4 * NDIG;
    localparam int SW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAXV = max_value(NDIG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    disp;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] clamped;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [NDIG-1:0]  blank;
    logic [3:0]       cur;
    logic             upper_zero;

    always_comb begin
        clamped = value;
        if (64'(value) > MAXV) clamped = MAXV[WIDTH-1:0];
    end

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // A load in any state restarts the conversion, discarding any pending commit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
            bcd   <= '0;
            step  <= '0;
            disp  <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                bin   <= clamped;
                bcd   <= '0;
                step  <= '0;
                busy  <= 1'b1;
                state <= CONV;
            end else begin
                case (state)
                    CONV: begin
                        bcd  <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
                        bin  <= {bin[WIDTH-2:0], 1'b0};
                        step <= step + SW'(1);
                        if (step == SW'(WIDTH - 1)) state <= COMMIT;
                    end
                    COMMIT: begin
                        disp  <= bcd;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Digit k is blank when it and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (disp[4*k +: 4] == 4'd0);
            blank[k]   = (BLANK_LZ != 0) && upper_zero;
        end
    end

    always_comb begin
        cur       = disp[4*int'(idx) +: 4];
        anode_n   = ~(NDIG'(1) << idx);
        digit_val = blank[idx] ? 32'd10 : {28'b0, cur};
    end

endmodule

// File: tb/tb_score_digit_scanner.sv
// tb/tb_score_digit_scanner.sv - directed table-driven bench for score_digit_scanner
module tb_score_digit_scanner;

    logic        clock;
    logic        reset_n;
    logic [13:0] value;
    logic        load;
    logic        busy, done, busy0, done0;
    logic [31:0] digit_val, digit_val0;
    logic [3:0]  anode_n, anode_n0;

    int errors = 0;
    int checks = 0;
    int ncyc;

    score_digit_scanner #(.NDIG(4), .WIDTH(14), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
        .clock(clock), .reset_n(reset_n), .value(value), .load(load),
        .busy(busy), .done(done), .digit_val(digit_val), .anode_n(anode_n));

    score_digit_scanner #(.NDIG(4), .WIDTH(14), .REFRESH_DIV(4), .BLANK_LZ(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .value(value), .load(load),
        .busy(busy0), .done(done0), .digit_val(digit_val0), .anode_n(anode_n0));

    initial begin
        clock = 1'b0;
        #50;
        forever #5 clock = ~clock;
    end

    // Reference scan position: counts edges since reset release.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ncyc <= 0;
        else ncyc <= ncyc + 1;
    end

    typedef struct packed {
        logic [13:0] val;
        logic [15:0] e1;
        logic [15:0] e0;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [13:0] v);
        @(negedge clock);
        value = v;
        load  = 1'b1;
        @(posedge clock);
        #1 load = 1'b0;
    endtask

    task automatic scan_check(input logic [15:0] e1, input logic [15:0] e0);
        int i;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            i = (ncyc / 4) % 4;
            chk("anode_n", {28'b0, anode_n}, {28'b0, ~(4'b0001 << i)});
            chk("digit_val_blank", digit_val, {28'b0, e1[4*i +: 4]});
            chk("digit_val_noblank", digit_val0, {28'b0, e0[4*i +: 4]});
        end
    endtask

    task automatic run_conv(input logic [13:0] v, input logic [15:0] e1, input logic [15:0] e0);
        logic ok;
        do_load(v);
        ok = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
        end
        chk("busy_window", {31'b0, ok}, 32'd1);
        @(negedge clock);
        chk("done_pulse", {30'b0, busy, done}, 32'd1);
        @(negedge clock);
        chk("done_clear", {31'b0, done}, 32'd0);
        scan_check(e1, e0);
    endtask

    initial begin
        logic ok;
        int   dcount;
        int   i;

        vecs[0] = '{val: 14'd1234,  e1: 16'h1234, e0: 16'h1234};
        vecs[1] = '{val: 14'd7,     e1: 16'hAAA7, e0: 16'h0007};
        vecs[2] = '{val: 14'd0,     e1: 16'hAAA0, e0: 16'h0000};
        vecs[3] = '{val: 14'd16383, e1: 16'h9999, e0: 16'h9999};
        vecs[4] = '{val: 14'd42,    e1: 16'hAA42, e0: 16'h0042};
        vecs[5] = '{val: 14'd9999,  e1: 16'h9999, e0: 16'h9999};
        vecs[6] = '{val: 14'd10000, e1: 16'h9999, e0: 16'h9999};
        vecs[7] = '{val: 14'd100,   e1: 16'hA100, e0: 16'h0100};

        reset_n = 1'b1;
        load    = 1'b0;
        value   = '0;
        #2 reset_n = 1'b0;
        #5;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_anode", {28'b0, anode_n}, 32'h0000000E);
        chk("rst_digit", digit_val, 32'd0);
        chk("rst_digit_noblank", digit_val0, 32'd0);
        #33 reset_n = 1'b1;

        for (int v = 0; v < 8; v++) run_conv(vecs[v].val, vecs[v].e1, vecs[v].e0);

        // Restart mid-conversion: only the second load commits.
        do_load(14'd1234);
        dcount = 0;
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (done) dcount++;
            i = (ncyc / 4) % 4;
            if (digit_val !== {28'b0, vecs[7].e1[4*i +: 4]}) ok = 1'b0;
        end
        @(negedge clock);
        if (done) dcount++;
        value = 14'd5678;
        load  = 1'b1;
        @(posedge clock);
        #1 load = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (done) dcount++;
            if (busy !== 1'b1) ok = 1'b0;
            i = (ncyc / 4) % 4;
            if (digit_val !== {28'b0, vecs[7].e1[4*i +: 4]}) ok = 1'b0;
        end
        chk("restart_hold_old", {31'b0, ok}, 32'd1);
        chk("restart_no_early_done", dcount, 32'd0);
        @(negedge clock);
        chk("restart_done", {30'b0, busy, done}, 32'd1);
        scan_check(16'h5678, 16'h5678);

        // Reset during a conversion, then a fresh conversion.
        do_load(14'd1234);
        for (int c = 0; c < 5; c++) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_anode", {28'b0, anode_n}, 32'h0000000E);
        chk("midrst_digit", digit_val, 32'd0);
        chk("midrst_digit_noblank", digit_val0, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        run_conv(14'd42, 16'hAA42, 16'h0042);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
